program_memory_arbiter: RTL and testbench

- Shares the single combinational program-memory read port between two requesters: instruction fetch (high priority) and a debug/data read port (low priority, starvation-protected).
- Sits between the fetch stage/debug unit and the program memory; drives the memory byte address, captures the returned word and delivers a registered, tagged response.
- Checks alignment and text-segment range before any access is granted.

---
 rtl/prog_mem_arb_pkg.sv | 6 +
 rtl/prog_addr_check.sv | 17 +
 rtl/program_memory_arbiter.sv | 119 +++++++++++
 tb/tb_program_memory_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/prog_mem_arb_pkg.sv
// Shared types and constants for the program-memory arbiter.
package prog_mem_arb_pkg;
  typedef enum logic [1:0] {GNT_NONE, GNT_FETCH, GNT_DBG} gnt_e;
  localparam logic [31:0] TEXT_BASE_DEF = 32'h0040_0000;
  localparam int          WORD_BYTES    = 4;
endpackage

// File: rtl/prog_addr_check.sv
// Combinational alignment / text-segment range check on a byte address.
module prog_addr_check
  import prog_mem_arb_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEF
)(
  input  logic [DATA_WIDTH-1:0] addr,
  output logic                  err
);
  localparam int              EW       = DATA_WIDTH + 1;
  // one extra bit so the segment end cannot wrap past the address space
  localparam logic [EW-1:0]   TEXT_END = {1'b0, TEXT_BASE} + EW'(WORD_BYTES * MEMORY_DEPTH);

  assign err = (addr[1:0] != 2'b00) || (addr < TEXT_BASE) || ({1'b0, addr} >= TEXT_END);
endmodule

// File: rtl/program_memory_arbiter.sv
// Two-requester program-memory read arbiter: fetch priority, starvation-protected debug.
// Optional statistics counters enabled by defining PMARB_STATS_EN.
module program_memory_arbiter
  import prog_mem_arb_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] TEXT_BASE    = TEXT_BASE_DEF,
  parameter int                    STARVE_LIMIT = 4
)(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [DATA_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_flush,
  output logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_instr,
  output logic                  fetch_err,
  input  logic                  dbg_req,
  input  logic [DATA_WIDTH-1:0] dbg_addr,
  output logic                  dbg_ready,
  output logic                  dbg_valid,
  output logic [DATA_WIDTH-1:0] dbg_data,
  output logic                  dbg_err,
`ifdef PMARB_STATS_EN
  output logic [31:0]           stat_fetch_cnt,
  output logic [31:0]           stat_dbg_cnt,
  output logic [15:0]           stat_err_cnt,
  output logic [15:0]           stat_starve_cnt,
`endif
  output logic [DATA_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_instr
);
  localparam int SW = 4;

  gnt_e                  gnt_q, gnt_d;
  logic [SW-1:0]         starve_cnt;
  logic                  force_dbg, gnt_fetch, gnt_dbg, gnt_err;
  logic [DATA_WIDTH-1:0] gnt_addr, addr_q, finstr_q, ddata_q;
  logic                  ferr_q, derr_q, flush_q;

  assign force_dbg = dbg_req && (starve_cnt == SW'(STARVE_LIMIT));
  assign gnt_dbg   = !reset && dbg_req && (!fetch_req || force_dbg);
  assign gnt_fetch = !reset && fetch_req && !gnt_dbg;
  // idle cycles keep the last granted address so the memory port never glitches
  assign gnt_addr  = gnt_fetch ? fetch_addr : (gnt_dbg ? dbg_addr : addr_q);
  assign mem_addr  = reset ? TEXT_BASE : gnt_addr;

  prog_addr_check #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .TEXT_BASE   (TEXT_BASE)
  ) u_chk (
    .addr(gnt_addr),
    .err (gnt_err)
  );

  always_comb begin
    gnt_d = GNT_NONE;
    if (gnt_fetch)    gnt_d = GNT_FETCH;
    else if (gnt_dbg) gnt_d = GNT_DBG;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt_q      <= GNT_NONE;
      starve_cnt <= '0;
      addr_q     <= TEXT_BASE;
      finstr_q   <= '0;
      ferr_q     <= 1'b0;
      ddata_q    <= '0;
      derr_q     <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      gnt_q   <= gnt_d;
      addr_q  <= gnt_addr;
      flush_q <= fetch_flush && gnt_fetch;
      if (gnt_fetch) begin
        finstr_q <= gnt_err ? '0 : mem_instr;
        ferr_q   <= gnt_err;
      end
      if (gnt_dbg) begin
        ddata_q <= gnt_err ? '0 : mem_instr;
        derr_q  <= gnt_err;
      end
      if (!dbg_req || gnt_dbg)                   starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // reset masks outputs immediately so a response in flight never surfaces
  always_comb begin
    fetch_ready = gnt_fetch;
    dbg_ready   = gnt_dbg;
    fetch_valid = !reset && (gnt_q == GNT_FETCH) && !flush_q;
    dbg_valid   = !reset && (gnt_q == GNT_DBG);
    fetch_err   = fetch_valid && ferr_q;
    dbg_err     = dbg_valid && derr_q;
    fetch_instr = reset ? '0 : finstr_q;
    dbg_data    = reset ? '0 : ddata_q;
  end

`ifdef PMARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_fetch_cnt  <= '0;
      stat_dbg_cnt    <= '0;
      stat_err_cnt    <= '0;
      stat_starve_cnt <= '0;
    end else begin
      if (gnt_fetch)                        stat_fetch_cnt  <= stat_fetch_cnt + 1'b1;
      if (gnt_dbg)                          stat_dbg_cnt    <= stat_dbg_cnt + 1'b1;
      if ((gnt_fetch || gnt_dbg) && gnt_err) stat_err_cnt   <= stat_err_cnt + 1'b1;
      if (gnt_dbg && fetch_req)             stat_starve_cnt <= stat_starve_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_program_memory_arbiter.sv
// Randomized scoreboard bench for program_memory_arbiter against a rule-level model.
module tb_program_memory_arbiter;
  localparam logic [31:0] TB    = 32'h0040_0000;
  localparam int          DEPTH = 32;
  localparam int          LIMIT = 4;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0, fetch_flush = 1'b0, dbg_req = 1'b0;
  logic [31:0] fetch_addr = '0, dbg_addr = '0;
  logic        fetch_ready, fetch_valid, fetch_err, dbg_ready, dbg_valid, dbg_err;
  logic [31:0] fetch_instr, dbg_data, mem_addr, mem_instr;
`ifdef PMARB_STATS_EN
  logic [31:0] stat_fetch_cnt, stat_dbg_cnt;
  logic [15:0] stat_err_cnt, stat_starve_cnt;
`endif

  logic [31:0] mem [DEPTH];
  rsp_t        fq[$], dq[$];
  int          checks = 0, failures = 0, cyc = 0;
  int          starve = 0;
  logic [31:0] last_ma = TB;
  logic        f_granted, d_granted;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  program_memory_arbiter #(
    .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(32), .TEXT_BASE(TB), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_instr(fetch_instr),
    .fetch_err(fetch_err),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_ready(dbg_ready),
    .dbg_valid(dbg_valid), .dbg_data(dbg_data), .dbg_err(dbg_err),
`ifdef PMARB_STATS_EN
    .stat_fetch_cnt(stat_fetch_cnt), .stat_dbg_cnt(stat_dbg_cnt),
    .stat_err_cnt(stat_err_cnt), .stat_starve_cnt(stat_starve_cnt),
`endif
    .mem_addr(mem_addr), .mem_instr(mem_instr)
  );

  // program memory: combinational read, garbage outside the segment
  always_comb begin
    logic [31:0] off;
    off = mem_addr - TB;
    mem_instr = (off < 32'(4 * DEPTH)) ? mem[off[6:2]] : 32'hDEAD_BEEF;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  function automatic rsp_t expect_rsp(input logic [31:0] a, input int due);
    rsp_t r;
    r.due = due;
    r.err = (a % 4 != 0) || (a < TB) || (a >= TB + 4 * DEPTH);
    r.data = r.err ? 32'h0 : mem[(a - TB) / 4];
    return r;
  endfunction

  // drive one cycle of stimulus, predict arbitration, queue expected responses
  task automatic step(input logic fr, input logic [31:0] fa, input logic fl,
                      input logic dr, input logic [31:0] da, input logic rs);
    logic gf, gd;
    logic [31:0] ema;
    @(posedge clk); #1;
    fetch_req = fr; fetch_addr = fa; fetch_flush = fl;
    dbg_req = dr; dbg_addr = da; reset = rs;
    #3;
    gf = 1'b0; gd = 1'b0;
    if (!rs) begin
      if (dr && (!fr || starve == LIMIT)) gd = 1'b1;
      else if (fr)                        gf = 1'b1;
    end
    chk("fetch_ready", 32'(fetch_ready), 32'(gf));
    chk("dbg_ready", 32'(dbg_ready), 32'(gd));
    ema = rs ? TB : (gf ? fa : (gd ? da : last_ma));
    chk("mem_addr", mem_addr, ema);
    if (rs) begin
      starve = 0; last_ma = TB;
    end else begin
      last_ma = ema;
      if (gf && !fl) fq.push_back(expect_rsp(fa, cyc + 1));
      if (gd)        dq.push_back(expect_rsp(da, cyc + 1));
      if (!dr || gd)            starve = 0;
      else if (starve < LIMIT)  starve = starve + 1;
    end
    f_granted = gf; d_granted = gd;
  endtask

  always @(negedge clk) begin
    rsp_t r;
    logic e;
    if (reset) begin
      chk("rst_fetch_valid", 32'(fetch_valid), 32'h0);
      chk("rst_dbg_valid", 32'(dbg_valid), 32'h0);
      chk("rst_fetch_instr", fetch_instr, 32'h0);
      chk("rst_dbg_data", dbg_data, 32'h0);
      chk("rst_mem_addr", mem_addr, TB);
      fq.delete(); dq.delete();
    end else begin
      e = (fq.size() != 0) && (fq[0].due == cyc);
      chk("fetch_valid", 32'(fetch_valid), 32'(e));
      if (e) begin
        r = fq.pop_front();
        if (fetch_valid) begin
          chk("fetch_instr", fetch_instr, r.data);
          chk("fetch_err", 32'(fetch_err), 32'(r.err));
        end
      end
      e = (dq.size() != 0) && (dq[0].due == cyc);
      chk("dbg_valid", 32'(dbg_valid), 32'(e));
      if (e) begin
        r = dq.pop_front();
        if (dbg_valid) begin
          chk("dbg_data", dbg_data, r.data);
          chk("dbg_err", 32'(dbg_err), 32'(r.err));
        end
      end
    end
  end

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 9);
    if (k < 7)       return TB + 32'(4 * $urandom_range(0, DEPTH - 1));
    else if (k == 7) return TB + 32'($urandom_range(0, 4 * DEPTH - 1));
    else if (k == 8) return TB + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 15));
    else             return TB - 32'(4 * $urandom_range(1, 8));
  endfunction

  initial begin
    logic fr, dr, fl, rs, fpend, dpend;
    logic [31:0] fa, da;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    // single fetch of word 2
    step(1, TB + 8, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // both requesting: debug forced in every fifth cycle
    for (int i = 0; i < 12; i++) step(1, TB + 32'h20, 0, 1, TB + 32'h10, 0);
    step(0, 0, 0, 0, 0, 0);
    // debug error cases
    step(0, 0, 0, 1, TB + 6, 0);
    step(0, 0, 0, 1, TB + 32'h80, 0);
    step(0, 0, 0, 0, 0, 0);
    // flushed fetch then a normal one
    step(1, TB, 1, 0, 0, 0);
    step(1, TB + 4, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // back-to-back fetches of words 0..3
    for (int i = 0; i < 4; i++) step(1, TB + 32'(4 * i), 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    // reset the cycle after a grant drops the response
    step(1, TB + 12, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    fpend = 1'b0; dpend = 1'b0; fr = 1'b0; dr = 1'b0; fa = TB; da = TB;
    for (int i = 0; i < 500; i++) begin
      if (!fpend) begin fr = ($urandom_range(0, 3) != 0); fa = rand_addr(); end
      if (!dpend) begin dr = ($urandom_range(0, 2) == 0); da = rand_addr(); end
      fl = fr && ($urandom_range(0, 7) == 0);
      rs = ($urandom_range(0, 99) == 0);
      step(fr, fa, fl, dr, da, rs);
      fpend = fr && !f_granted;
      dpend = dr && !d_granted;
    end
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk); #4;
    chk("fetch_queue_drained", 32'(fq.size()), 32'h0);
    chk("dbg_queue_drained", 32'(dq.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
